// File: rtl/sobel_uart_edge.sv
// Sobel edge detector between a UART receiver and a UART transmitter, 8N1 on both lines.
// Pixels arrive in raster order; each full 3x3 window yields one thresholded byte (0xFF or 0x00) on tx.
module sobel_uart_edge #(
   parameter int          BAUD_CNT_END      = 433,
   parameter int          BAUD_CNT_END_HALF = 216,
   parameter int          IMG_W             = 200,
   parameter int          IMG_H             = 200,
   parameter logic [10:0] THRESH            = 11'd100
) (
   input  logic sclk,
   input  logic rst_n,
   input  logic rx,
   output logic tx
);
   localparam int BW = $clog2(BAUD_CNT_END + 1);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [BW-1:0] B_END   = BW'(BAUD_CNT_END);
   localparam logic [BW-1:0] B_HALF  = BW'(BAUD_CNT_END_HALF);
   localparam logic [CW-1:0] COL_END = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_END = RW'(IMG_H - 1);

   typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

   // rst_n is active high despite its name
   logic rst;
   assign rst = rst_n;

   function automatic logic signed [10:0] ext_pix(input logic [7:0] p);
      return signed'({3'b000, p});
   endfunction

   function automatic logic [10:0] abs11(input logic signed [10:0] v);
      return v[10] ? 11'(-v) : 11'(v);
   endfunction

   function automatic logic [7:0] thresh_bin(input logic [10:0] m);
      return (m >= THRESH) ? 8'hFF : 8'h00;
   endfunction

   rx_state_t     rx_state_q;
   logic          rx_s1_q, rx_s2_q, rx_s3_q;
   logic [BW-1:0] rx_baud_q;
   logic [3:0]    rx_bit_q;
   logic [7:0]    rx_sh_q, rx_data_q;
   logic          rx_valid_q;

   always_ff @(posedge sclk) begin
      if (rst) begin
         rx_state_q <= RX_IDLE;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
         rx_valid_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_s3_q && !rx_s2_q) begin
                  rx_state_q <= RX_BUSY;
                  rx_baud_q  <= '0;
                  rx_bit_q   <= '0;
               end
            end
            RX_BUSY: begin
               rx_baud_q <= (rx_baud_q == B_END) ? '0 : rx_baud_q + 1'b1;
               if (rx_baud_q == B_END) rx_bit_q <= rx_bit_q + 4'd1;
               if (rx_baud_q == B_HALF) begin
                  if (rx_bit_q == 4'd0) begin
                     if (rx_s2_q) rx_state_q <= RX_IDLE;
                  end else if (rx_bit_q == 4'd9) begin
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= rx_sh_q;
                     rx_state_q <= RX_IDLE;
                  end else begin
                     rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
                  end
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   // Stage p0: raster counters, line buffers and the 3x3 window (row 0 oldest, column 2 newest)
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [7:0]    lb1_q [IMG_W];
   logic [7:0]    lb2_q [IMG_W];
   logic [7:0]    up1, up2;
   logic [7:0]    w_q [3][3];
   logic          vld_p0_q;

   assign up1 = lb1_q[col_q];
   assign up2 = lb2_q[col_q];

   always_comb begin
      col_d = col_q + 1'b1;
      row_d = row_q;
      if (col_q == COL_END) begin
         col_d = '0;
         row_d = (row_q == ROW_END) ? '0 : row_q + 1'b1;
      end
   end

   always_ff @(posedge sclk) begin
      if (rx_valid_q) begin
         lb2_q[col_q] <= up1;
         lb1_q[col_q] <= rx_data_q;
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         col_q    <= '0;
         row_q    <= '0;
         vld_p0_q <= 1'b0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) w_q[r][c] <= '0;
      end else begin
         vld_p0_q <= rx_valid_q && (row_q >= RW'(2)) && (col_q >= CW'(2));
         if (rx_valid_q) begin
            col_q <= col_d;
            row_q <= row_d;
            for (int r = 0; r < 3; r++) begin
               w_q[r][0] <= w_q[r][1];
               w_q[r][1] <= w_q[r][2];
            end
            w_q[0][2] <= up2;
            w_q[1][2] <= up1;
            w_q[2][2] <= rx_data_q;
         end
      end
   end

   // Stage p1: gradient magnitude; the threshold is applied combinationally on the registered magnitude
   logic signed [10:0] gx_p0, gy_p0;
   logic [10:0]        mag_p0, mag_p1_q;
   logic               vld_p1_q;
   logic [7:0]         res_p1;

   always_comb begin
      gx_p0 = (ext_pix(w_q[0][2]) + (ext_pix(w_q[1][2]) <<< 1) + ext_pix(w_q[2][2]))
            - (ext_pix(w_q[0][0]) + (ext_pix(w_q[1][0]) <<< 1) + ext_pix(w_q[2][0]));
      gy_p0 = (ext_pix(w_q[2][0]) + (ext_pix(w_q[2][1]) <<< 1) + ext_pix(w_q[2][2]))
            - (ext_pix(w_q[0][0]) + (ext_pix(w_q[0][1]) <<< 1) + ext_pix(w_q[0][2]));
      mag_p0 = abs11(gx_p0) + abs11(gy_p0);
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         mag_p1_q <= '0;
      end else begin
         vld_p1_q <= vld_p0_q;
         mag_p1_q <= mag_p0;
      end
   end

   assign res_p1 = thresh_bin(mag_p1_q);

   // TX: a result may bypass the holding register, and frames chain without an idle gap
   tx_state_t     tx_state_q;
   logic          tx_q;
   logic [8:0]    tx_sh_q;
   logic [BW-1:0] tx_baud_q;
   logic [3:0]    tx_bit_q;
   logic [7:0]    hold_q, tx_load;
   logic          hold_full_q, tx_free, tx_take;

   always_comb begin
      tx_free = (tx_state_q == TX_IDLE) || ((tx_baud_q == B_END) && (tx_bit_q == 4'd9));
      tx_take = tx_free && (hold_full_q || vld_p1_q);
      tx_load = hold_full_q ? hold_q : res_p1;
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         tx_state_q  <= TX_IDLE;
         tx_q        <= 1'b1;
         tx_sh_q     <= '0;
         tx_baud_q   <= '0;
         tx_bit_q    <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         if (vld_p1_q && !(tx_take && !hold_full_q)) begin
            hold_q      <= res_p1;
            hold_full_q <= 1'b1;
         end else if (tx_take) begin
            hold_full_q <= 1'b0;
         end
         if (tx_take) begin
            tx_state_q <= TX_SEND;
            tx_q       <= 1'b0;
            tx_sh_q    <= {1'b1, tx_load};
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
         end else if (tx_state_q == TX_SEND) begin
            if (tx_baud_q == B_END) begin
               tx_baud_q <= '0;
               if (tx_bit_q == 4'd9) begin
                  tx_state_q <= TX_IDLE;
                  tx_q       <= 1'b1;
               end else begin
                  tx_bit_q <= tx_bit_q + 4'd1;
                  tx_q     <= tx_sh_q[0];
                  tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
               end
            end else begin
               tx_baud_q <= tx_baud_q + 1'b1;
            end
         end
      end
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_sobel_uart_edge.sv
// Scoreboard bench for sobel_uart_edge on a small 8x6 image at 8 clocks per UART bit.
// Stimulus pushes hand-derived result bytes; a tx decoder pops and compares them.
module tb_sobel_uart_edge;
   localparam int BE   = 7;
   localparam int BH   = 3;
   localparam int BIT  = BE + 1;
   localparam int W    = 8;
   localparam int H    = 6;
   localparam int NOUT = (W - 2) * (H - 2);

   logic sclk = 1'b0;
   logic rst_n;
   logic rx;
   logic tx;

   always #5 sclk = ~sclk;

   sobel_uart_edge #(
      .BAUD_CNT_END      (BE),
      .BAUD_CNT_END_HALF (BH),
      .IMG_W             (W),
      .IMG_H             (H),
      .THRESH            (11'd100)
   ) dut (
      .sclk  (sclk),
      .rst_n (rst_n),
      .rx    (rx),
      .tx    (tx)
   );

   int         tests = 0;
   int         fails = 0;
   int         rx_bytes = 0;
   int         rxv_cnt = 0;
   logic [7:0] rxv_last = 8'h00;
   bit         mon_en = 1'b0;
   logic [7:0] expq[$];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Pixel patterns: 0 flat, 1 vertical 0|FF, 2 horizontal 0/FF, 3 vertical 0|25, 4 vertical 0|24, 5 horizontal FF/0
   function automatic logic [7:0] pix(input int kind, input int r, input int c);
      case (kind)
         1:       return (c >= W / 2) ? 8'hFF : 8'h00;
         2:       return (r >= H / 2) ? 8'hFF : 8'h00;
         3:       return (c >= W / 2) ? 8'd25 : 8'h00;
         4:       return (c >= W / 2) ? 8'd24 : 8'h00;
         5:       return (r <  H / 2) ? 8'hFF : 8'h00;
         default: return 8'h80;
      endcase
   endfunction

   // A 0->v step of width one column gives |Gx| = 4*v at the two centres straddling it
   function automatic logic [7:0] exp_out(input int kind, input int orow, input int ocol);
      case (kind)
         1, 3:    return (ocol == W / 2 - 2 || ocol == W / 2 - 1) ? 8'hFF : 8'h00;
         2, 5:    return (orow == H / 2 - 2 || orow == H / 2 - 1) ? 8'hFF : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic send_byte(input logic [7:0] d);
      rx = 1'b0;
      repeat (BIT) @(negedge sclk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (BIT) @(negedge sclk);
      end
      rx = 1'b1;
      repeat (BIT) @(negedge sclk);
   endtask

   task automatic send_frame(input int kind);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (r >= 2 && c >= 2) expq.push_back(exp_out(kind, r - 2, c - 2));
            send_byte(pix(kind, r, c));
         end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (expq.size() != 0 && n < 4000) begin
         @(negedge sclk);
         n++;
      end
      check({name, "_missing"}, expq.size(), 0);
      expq.delete();
      repeat (30 * BIT) @(negedge sclk);
   endtask

   task automatic do_reset();
      @(negedge sclk);
      rst_n = 1'b1;
      repeat (2) @(negedge sclk);
      rst_n = 1'b0;
   endtask

   always @(negedge sclk) begin
      if (dut.rx_valid_q) begin
         rxv_cnt  <= rxv_cnt + 1;
         rxv_last <= dut.rx_data_q;
      end
   end

   // tx decoder: samples each bit near its middle
   initial begin : monitor
      logic [7:0] b;
      logic       sb, st;
      logic [7:0] e;
      forever begin
         @(negedge sclk);
         if (mon_en && tx === 1'b0) begin
            repeat (BIT / 2) @(negedge sclk);
            sb = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge sclk);
               b[i] = tx;
            end
            repeat (BIT) @(negedge sclk);
            st = tx;
            rx_bytes++;
            check("tx_framing", int'({sb, st}), 1);
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tx_unexpected: got byte 0x%02h, expected no byte", b);
            end else begin
               e = expq.pop_front();
               check("tx_byte", int'(b), int'(e));
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation exceeded its time budget, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int bad;
      int base;
      int nb;
      rst_n = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge sclk);
      rst_n = 1'b0;
      check("reset_tx", int'(tx), 1);
      bad = 0;
      repeat (300) begin
         @(negedge sclk);
         if (tx !== 1'b1) bad++;
      end
      check("idle_tx_low_cycles", bad, 0);
      check("idle_rx_valid", rxv_cnt, 0);
      mon_en = 1'b1;

      base = rxv_cnt;
      nb   = rx_bytes;
      send_byte(8'h5A);
      repeat (2 * BIT) @(negedge sclk);
      check("single_rx_valid_pulses", rxv_cnt - base, 1);
      check("single_rx_data", int'(rxv_last), 'h5A);
      repeat (20 * BIT) @(negedge sclk);
      check("single_no_tx", rx_bytes - nb, 0);

      do_reset();
      nb = rx_bytes;
      send_frame(0);
      drain("flat");
      check("flat_count", rx_bytes - nb, NOUT);

      nb = rx_bytes;
      for (int k = 1; k <= 5; k++) send_frame(k);
      drain("back_to_back");
      check("back_to_back_count", rx_bytes - nb, 5 * NOUT);

      nb = rx_bytes;
      for (int i = 0; i < 10; i++) send_byte(8'h80);
      do_reset();
      send_frame(0);
      drain("reset_mid_frame");
      check("reset_mid_frame_count", rx_bytes - nb, NOUT);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sobel_uart_edge.md
Name: sobel_uart_edge

Overview:
- Stand-alone Sobel edge detector with a UART on each side.
- Receives an 8-bit grayscale image, IMG_W x IMG_H pixels in raster order, over a UART RX line at 8N1.
- Computes a 3x3 Sobel gradient magnitude per valid window and thresholds it to 0xFF or 0x00.
- Streams each binary result byte back over a UART TX line.

Parameters:
- BAUD_CNT_END, 433: clocks per UART bit minus 1 (50 MHz / 115200).
- BAUD_CNT_END_HALF, 216: mid-bit sample point for RX.
- IMG_W, 200: pixels per row.
- IMG_H, 200: rows per frame.
- THRESH, 11'd100: edge threshold on |Gx|+|Gy|.

Ports:
- sclk  input  1  system clock, 50 MHz.
- rst_n  input  1  one clock; reset is synchronous and active-high. Reset is asserted when rst_n=1, despite the name.
- rx  input  1  UART receive line, idle high, asynchronous to sclk.
- tx  output  1  UART transmit line, idle high.

Behaviour:
- Reset clears all counters, line buffers' read/write pointers, window registers, the TX holding register and all state, and drives tx=1. Reset mid-frame discards the partial frame; the next received byte is pixel (0,0).
- RX:
  - rx passes through a 2-flop synchronizer.
  - A falling edge while idle starts a frame. A baud counter runs 0..BAUD_CNT_END.
  - Each bit is sampled when the counter equals BAUD_CNT_END_HALF: start bit, then 8 data bits LSB first, then stop bit.
  - At the stop-bit sample point, rx_valid pulses for 1 clock with rx_data[7:0]. The receiver then returns to idle.
  - A start bit sampled high aborts the frame with no rx_valid.
  - The stop-bit value is not checked.
- Pixel counters:
  - col 0..IMG_W-1 and row 0..IMG_H-1 advance on each rx_valid.
  - col wraps to 0 and increments row. After (IMG_W-1, IMG_H-1) both wrap to 0, so the next frame starts.
- Line buffers:
  - Two IMG_W x 8 memories hold rows r-1 and r-2, indexed by col.
  - On rx_valid: read both at col, shift the buffers (r-2 <= r-1, r-1 <= new pixel), and shift the 3x3 window left by one column. The new right column is {r-2, r-1, new}.
  - The window is p11..p33; row 1 is oldest, column 3 is newest.
- Sobel (1 clock after rx_valid):
  - Gx = (p13 + 2*p23 + p33) - (p11 + 2*p21 + p31).
  - Gy = (p31 + 2*p32 + p33) - (p11 + 2*p12 + p13).
  - Signed 11-bit arithmetic; mag = |Gx| + |Gy|, 11 bits unsigned, max 2040.
- Threshold (2nd clock): result = 8'hFF if mag >= THRESH, else 8'h00.
- A result is produced only for rx_valid with row >= 2 and col >= 2 of the incoming pixel. Output per frame is (IMG_W-2)*(IMG_H-2) bytes: 39204 by default, in raster order.
- Latency: result_valid asserts exactly 2 clocks after the qualifying rx_valid.
- TX:
  - A one-entry holding register accepts result_valid.
  - When the transmitter is idle and the holding register is full, it loads and sends start bit 0, 8 data bits LSB first, then stop bit 1. Each bit lasts BAUD_CNT_END+1 clocks, 10 bits per frame.
  - TX frame time equals RX frame time, so no overflow occurs at line rate. If a new result arrives while the holding register is still full, it overwrites it; this is not expected at line rate.
- Simultaneous rx_valid and TX load are independent. rx_valid during the last pixel of a row updates the counters with wrap in the same cycle.

Test Plan:
- Idle: after reset, hold rx=1 for 10000 clocks -> tx stays 1, no activity.
- Single byte 0x5A, 434 clocks/bit -> internal rx_valid pulses once with rx_data=0x5A near the middle of the stop bit; no tx output.
- Flat image, 40000 bytes of 0x80 -> exactly 39204 TX bytes, all 0x00. Each TX frame is 4340 clocks (start 0, stop 1). The first TX start bit begins 2-3 clocks after the rx_valid of pixel (2,2).
- Vertical edge: columns 0..99 = 0x00, columns 100..199 = 0xFF -> for every output row, the bytes at window centres col 99 and 100 (output indices 98, 99 within each 198-byte row) are 0xFF (|Gx| = 1020); all others are 0x00.
- Horizontal edge: rows 0..99 = 0x00, rows 100..199 = 0xFF -> output rows for centre rows 99 and 100 are all 0xFF; all others are 0x00.
- Reset mid-frame after 1000 bytes, then a fresh flat frame -> again exactly 39204 0x00 bytes. Two back-to-back frames -> 78408 bytes total, with no extra or missing bytes at the frame boundary.
